// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  localparam int DATA_W = 16;

endpackage

// File: rtl/mem_access_ctrl_dff.sv
// dff_16bit: write-enabled data register with async active-low clear (read-data latch).
module dff_16bit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: req/ack handshake with a variable-latency data memory, upstream stall.
// Optional abort of a hung access when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int DATA_W         = mem_stage_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_mem_write,
  input  logic              in_mem_read,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_alu_val,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_stall,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_alu_val,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              mem_err
);
  import mem_stage_pkg::*;

  mem_state_t        state, next_state;
  logic              issue;
  logic              timeout_hit;
  logic              we_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] rdata_q;

  // Gating with rst_n drops the request the moment reset asserts, even with access inputs high.
  assign issue = rst_n && (in_mem_read || in_mem_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we_p1 <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && issue) we_p1 <= in_mem_write;
    end
  end

  // Stage p0 -> p1: request address/data held stable for the WAIT phase.
  always_ff @(posedge clk) begin
    if (state == IDLE && issue) begin
      addr_p1  <= in_alu_val;
      wdata_p1 <= in_store_data;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_stall  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (issue) begin
          mem_req    = 1'b1;
          mem_stall  = 1'b1;
          mem_we     = in_mem_write;
          mem_addr   = in_alu_val;
          mem_wdata  = in_store_data;
          next_state = WAIT;
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        mem_we    = we_p1;
        mem_addr  = addr_p1;
        mem_wdata = wdata_p1;
        if (mem_ack || timeout_hit) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt_p1;
  logic             timeout_p1;

  // Counter holds (WAIT cycles elapsed - 1); the last allowed WAIT cycle aborts unless acked.
  assign timeout_hit = (state == WAIT) && !mem_ack &&
                       (wait_cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_p1 <= '0;
      timeout_p1  <= 1'b0;
    end else begin
      wait_cnt_p1 <= (state == WAIT && next_state == WAIT) ? wait_cnt_p1 + 1'b1 : '0;
      timeout_p1  <= timeout_hit;
    end
  end

  assign mem_err = (state == DONE) && timeout_p1;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign timeout_hit           = 1'b0;
  assign mem_err               = 1'b0;
`endif

  // Stage p1 -> p2: read data captured on ack, presented to MEM/WB.
  dff_16bit #(.W(DATA_W)) u_rdata_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   ((state == WAIT) && mem_ack && !we_p1),
    .d     (mem_rdata),
    .q     (rdata_q)
  );

  assign wb_mem_to_reg = in_mem_to_reg;
  assign wb_alu_val    = in_alu_val;
  assign wb_reg_write  = rst_n && in_reg_write && !mem_stall && !mem_err;
  assign wb_mem_data   = mem_err ? '0 : rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: per-scenario tasks with a read-data scoreboard.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
  logic [15:0] in_alu_val, in_store_data;
  logic        mem_req, mem_we, mem_ack, mem_stall;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_mem_to_reg, wb_reg_write, mem_err;
  logic [15:0] wb_alu_val, wb_mem_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_latch = 16'h0000;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_mem_write  (in_mem_write),
    .in_mem_read   (in_mem_read),
    .in_mem_to_reg (in_mem_to_reg),
    .in_reg_write  (in_reg_write),
    .in_alu_val    (in_alu_val),
    .in_store_data (in_store_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .mem_stall     (mem_stall),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_alu_val    (wb_alu_val),
    .wb_mem_data   (wb_mem_data),
    .mem_err       (mem_err)
  );

  // Issue one access, hold it `waits` WAIT cycles (ack in the last), then check DONE.
  task automatic do_access(input string tag, input logic wr, input logic rd, input logic rw,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int waits,
                           input logic ack_issue, input logic ack_done);
    logic [15:0] exp_data;
    @(negedge clk);
    in_mem_write = wr; in_mem_read = rd; in_mem_to_reg = rd & ~wr; in_reg_write = rw;
    in_alu_val = addr; in_store_data = wdata;
    mem_ack = ack_issue; mem_rdata = 16'hDEAD;
    if (rd && !wr) exp_latch = rdata;
    sb_q.push_back(exp_latch);
    #1;
    n_checks++;
    if ({mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write} !== {2'b11, wr, addr, wdata, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_issue: req/stall/we/addr/wdata/wbrw got %b/%b/%b/%h/%h/%b want 1/1/%b/%h/%h/0",
               tag, mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write, wr, addr, wdata);
    end
    for (int k = 1; k <= waits; k++) begin
      @(negedge clk);
      in_alu_val = 16'($urandom); in_store_data = 16'($urandom);
      mem_ack = (k == waits);
      mem_rdata = (k == waits) ? rdata : 16'($urandom);
      #1;
      n_checks++;
      if ({mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write} !== {2'b11, wr, addr, wdata, 1'b0}) begin
        n_fail++;
        $display("FAIL %s_wait%0d: req/stall/we/addr/wdata/wbrw got %b/%b/%b/%h/%h/%b want 1/1/%b/%h/%h/0",
                 tag, k, mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write, wr, addr, wdata);
      end
    end
    @(negedge clk);
    mem_ack = ack_done; mem_rdata = 16'hBAD0;
    in_alu_val = addr; in_store_data = wdata;
    #1;
    n_checks++;
    if ({mem_req, mem_stall, wb_reg_write, mem_err} !== {2'b00, rw, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_done: req/stall/wbrw/err got %b/%b/%b/%b want 0/0/%b/0",
               tag, mem_req, mem_stall, wb_reg_write, mem_err, rw);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: scoreboard empty at DONE, got data %h", tag, wb_mem_data);
    end else begin
      exp_data = sb_q.pop_front();
      if (wb_mem_data !== exp_data) begin
        n_fail++;
        $display("FAIL %s_data: wb_mem_data got %h want %h", tag, wb_mem_data, exp_data);
      end
    end
    n_checks++;
    if (wb_alu_val !== addr) begin
      n_fail++;
      $display("FAIL %s_alu: wb_alu_val got %h want %h", tag, wb_alu_val, addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_mem_write = 1'b0; in_mem_read = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
    in_alu_val = 16'h5A5A; in_store_data = 16'h1111; mem_ack = 1'b0; mem_rdata = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write, wb_mem_data, mem_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: req/stall/we/addr/wdata/wbrw/wbdata/err got %b/%b/%b/%h/%h/%b/%h/%b want all 0",
               mem_req, mem_stall, mem_we, mem_addr, mem_wdata, wb_reg_write, wb_mem_data, mem_err);
    end
    n_checks++;
    if ({wb_mem_to_reg, wb_alu_val} !== {1'b1, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL reset_pass: m2r/alu got %b/%h want 1/5a5a", wb_mem_to_reg, wb_alu_val);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_only();
    @(negedge clk);
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b1;
    in_alu_val = 16'h1234; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    n_checks++;
    if ({mem_req, mem_stall, wb_reg_write, wb_mem_to_reg, wb_alu_val} !== {4'b0010, 16'h1234}) begin
      n_fail++;
      $display("FAIL alu_only: req/stall/wbrw/m2r/alu got %b/%b/%b/%b/%h want 0/0/1/0/1234",
               mem_req, mem_stall, wb_reg_write, wb_mem_to_reg, wb_alu_val);
    end
    @(negedge clk);
    mem_ack = 1'b0; in_reg_write = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, wb_mem_data} !== {1'b0, exp_latch}) begin
      n_fail++;
      $display("FAIL idle_ack: req/wbdata got %b/%h want 0/%h", mem_req, wb_mem_data, exp_latch);
    end
  endtask

  task automatic test_load();
    do_access("load", 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b1, 1'b0);
  endtask

  task automatic test_store();
    do_access("store", 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 16'h5555, 1, 1'b0, 1'b1);
    @(negedge clk);
    in_mem_write = 1'b0; mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_stall, wb_mem_data} !== {2'b00, exp_latch}) begin
      n_fail++;
      $display("FAIL done_ack: req/stall/wbdata got %b/%b/%h want 0/0/%h", mem_req, mem_stall, wb_mem_data, exp_latch);
    end
  endtask

  task automatic test_back_to_back();
    do_access("b2b_ld", 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'hC0DE, 2, 1'b0, 1'b0);
    do_access("b2b_st", 1'b1, 1'b0, 1'b0, 16'h0204, 16'h0F0F, 16'h1357, 1, 1'b0, 1'b0);
    do_access("both",   1'b1, 1'b1, 1'b0, 16'h0300, 16'h7E7E, 16'h9999, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    in_mem_write = 1'b0; in_mem_read = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
    in_alu_val = 16'h0080; mem_ack = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_wait: req/stall got %b/%b want 0/0", mem_req, mem_stall);
    end
    exp_latch = 16'h0000;
    @(negedge clk);
    in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_stall, wb_mem_data} !== {2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL rst_idle: req/stall/wbdata got %b/%b/%h want 0/0/0000", mem_req, mem_stall, wb_mem_data);
    end
    do_access("after_rst", 1'b0, 1'b1, 1'b1, 16'h0088, 16'h0000, 16'h4242, 1, 1'b0, 1'b0);
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    in_mem_write = 1'b0; in_mem_read = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
    in_alu_val = 16'h0100; mem_ack = 1'b0; mem_rdata = 16'hFFFF;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_req, mem_err} !== 2'b10) begin
        n_fail++;
        $display("FAIL to_wait%0d: req/err got %b/%b want 1/0", k, mem_req, mem_err);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({mem_req, mem_stall, mem_err, wb_reg_write, wb_mem_data} !== {4'b0010, 16'h0000}) begin
      n_fail++;
      $display("FAIL to_done: req/stall/err/wbrw/wbdata got %b/%b/%b/%b/%h want 0/0/1/0/0000",
               mem_req, mem_stall, mem_err, wb_reg_write, wb_mem_data);
    end
    @(negedge clk);
    in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_err, wb_mem_data} !== {2'b00, exp_latch}) begin
      n_fail++;
      $display("FAIL to_after: req/err/wbdata got %b/%b/%h want 0/0/%h", mem_req, mem_err, wb_mem_data, exp_latch);
    end
  endtask
`else
  task automatic test_timeout();
    @(negedge clk);
    in_mem_write = 1'b0; in_mem_read = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
    in_alu_val = 16'h0100; mem_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_req, mem_stall, mem_err} !== 3'b110) begin
        n_fail++;
        $display("FAIL hold_wait%0d: req/stall/err got %b/%b/%b want 1/1/0", k, mem_req, mem_stall, mem_err);
      end
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h7777; exp_latch = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_err, wb_reg_write, wb_mem_data} !== {3'b001, 16'h7777}) begin
      n_fail++;
      $display("FAIL hold_done: req/err/wbrw/wbdata got %b/%b/%b/%h want 0/0/1/7777",
               mem_req, mem_err, wb_reg_write, wb_mem_data);
    end
    @(negedge clk);
    in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_only();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
